prng_arbiter: RTL and testbench
===============================

Name: prng_arbiter

Overview:
Round-robin scheduler that shares one 4-bit PRNG nibble generator among N requesters. It drives the generator's `ena` and `res` inputs and detects each completed nibble on the generator's `done` flag. It packs WORD_NIBBLES nibbles into one word per grant and returns that word to the granted requester with a one-cycle acknowledge. It sits between the random-number consumers and the single PRNG instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WORD_NIBBLES, 2, nibbles packed per delivered word (1..8); word width W = 4*WORD_NIBBLES.
- TIMEOUT_CYCLES, 255, watchdog limit in COLLECT; used only with PRNG_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all logic on posedge.
- res  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level; held until ack.
- ack  out  N_REQ  one-hot, one-cycle pulse; rsp_data is valid in that cycle.
- rsp_data  out  W  shared response word.
- busy  out  1  high whenever the state is not IDLE.
- timeout_err  out  1  one-cycle watchdog pulse; tied 0 without the macro.
- prng_ena  out  1  registered enable to the PRNG.
- prng_res  out  1  registered reset to the PRNG.
- prng_dout  in  4  PRNG nibble.
- prng_done  in  1  PRNG nibble-complete flag.

Behaviour:
- Reset, while res=1 at an edge:
  - state=IDLE; ack=0; rsp_data=0; busy=0; timeout_err=0; prng_ena=0.
  - Round-robin pointer=0; nibble count=0; done_q=0.
  - prng_res=1 during reset and for exactly one cycle after res falls.
- Nibble detect: done_q<=prng_done every cycle, in every state. A nibble is taken only when prng_done=1 and done_q=0, with state=COLLECT. A done level held high across a pause never counts twice.
- States:
  - IDLE:
    - If any req bit is high, pick the first set bit at or after the pointer, wrapping modulo N_REQ.
    - Register the grant, clear the word and count, go to COLLECT. prng_ena=1 from the next edge.
    - Decision takes one cycle. No grant is made in the cycle prng_res=1.
  - COLLECT:
    - prng_ena held 1.
    - On each detected nibble k (0-based), write word[4k+3:4k]=prng_dout, LSB nibble first.
    - When k reaches WORD_NIBBLES-1, go to DELIVER. prng_ena falls at that same edge.
  - DELIVER (1 cycle):
    - rsp_data=word.
    - ack[grant]=1 only if req[grant] is still high; otherwise the word is discarded silently.
    - Pointer<=grant+1 mod N_REQ. Go to IDLE.
- Minimum grant-to-ack spacing: back-to-back grants are separated by at least one IDLE cycle.
- PRNG state is not reset between grants. Its partial-nibble progress carries over.
- After any reset, the first word's latency includes the PRNG warm-up of 34 enabled cycles.
- A requester dropping req mid-COLLECT does not abort collection. Collection finishes and the word is discarded.
- res mid-operation aborts immediately: no ack, partial word discarded, prng_res pulse re-issued.
- rsp_data holds its last value outside DELIVER. Consumers sample it only on ack.

Optional Feature:
- Macro: PRNG_ARB_TIMEOUT_EN.
- With the macro:
  - A cycle counter runs in COLLECT and clears on every detected nibble.
  - When it reaches TIMEOUT_CYCLES, the block pulses timeout_err for 1 cycle, deasserts prng_ena, and pulses prng_res for 1 cycle.
  - The grant is dropped without ack, the pointer advances past it, and the state returns to IDLE.
- Without the macro: no counter is built, timeout_err is constant 0, and COLLECT waits indefinitely.

Decomposition:
- Shared package prng_pkg holds:
  - state enum (IDLE, COLLECT, DELIVER);
  - PRNG_NIBBLE_W=4;
  - PRNG_WARMUP_CYCLES=34;
  - PRNG_NIBBLE_CYCLES=4.
- One sub-module, rr_arbiter_n: a pure round-robin picker taking req and pointer and returning a one-hot grant and a valid flag. It is reusable elsewhere.

Test Plan:
- Reset with req=0001; PRNG model instantiated; WORD_NIBBLES=2 -> prng_res high 1 cycle after reset; ack[0] arrives no earlier than 34+8 enabled cycles after grant; rsp_data equals the two nibbles, first nibble in [3:0].
- req=1111 held continuously -> acks issued in order 0,1,2,3,0; no requester acked twice before all others.
- req[2] dropped mid-COLLECT while req[3]=1 -> no ack[2]; next grant goes to 3; busy stays 1 through DELIVER.
- prng_done forced high across an IDLE pause -> no spurious nibble on re-entry; the word contains only nibbles from new rising edges.
- res=1 in the middle of COLLECT -> ack stays 0; prng_ena=0; prng_res high for reset plus 1 cycle; next grant starts from pointer 0.
- PRNG_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10, prng_done stuck at 0 -> timeout_err pulses on cycle 10 of COLLECT; no ack; next requester granted.

Source files
------------

// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG arbiter slice.
// Holds the scheduler state encoding and the nibble generator's timing facts.
// No ports; imported by prng_arbiter and its consumers.
package prng_pkg;

  localparam int PRNG_NIBBLE_W      = 4;
  localparam int PRNG_WARMUP_CYCLES = 34;  // enabled cycles before the first nibble
  localparam int PRNG_NIBBLE_CYCLES = 4;   // enabled cycles per nibble thereafter

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DELIVER = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin picker: one-hot grant of the first set req bit at or after ptr.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when a grant is consumed.
// Ports: req[N] requests, ptr start index, grant[N] one-hot, valid = any req.
module rr_arbiter_n #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    valid = |req;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      // Walk from ptr upward, wrapping modulo N.
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prng_arbiter.sv
// Shares one 4-bit PRNG among N_REQ requesters; packs WORD_NIBBLES nibbles per grant.
// Latency: grant 1 cycle after req in IDLE, then PRNG-bound collection, ack 1 cycle in DELIVER.
// Backpressure: req is a held level; a word whose requester dropped req is discarded.
// Ports: clk/res (sync, active-high); req/ack/rsp_data to consumers; busy; timeout_err;
//        prng_ena/prng_res/prng_dout/prng_done to the shared generator.
// Optional: define PRNG_ARB_TIMEOUT_EN to build the COLLECT watchdog (TIMEOUT_CYCLES).
module prng_arbiter
  import prng_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int WORD_NIBBLES   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              res,
  input  logic [N_REQ-1:0]                  req,
  output logic [N_REQ-1:0]                  ack,
  output logic [PRNG_NIBBLE_W*WORD_NIBBLES-1:0] rsp_data,
  output logic                              busy,
  output logic                              timeout_err,
  output logic                              prng_ena,
  output logic                              prng_res,
  input  logic [PRNG_NIBBLE_W-1:0]          prng_dout,
  input  logic                              prng_done
);

  localparam int W  = PRNG_NIBBLE_W * WORD_NIBBLES;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (WORD_NIBBLES > 1) ? $clog2(WORD_NIBBLES) : 1;

  arb_state_t       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gnt_idx;
  logic [N_REQ-1:0] gnt_oh;
  logic [W-1:0]     word;
  logic [W-1:0]     word_nxt;
  logic [CW-1:0]    nib_cnt;
  logic             done_q;
  logic             res_q;     // stretches prng_res one cycle past reset release
  logic [N_REQ-1:0] arb_gnt;
  logic             arb_vld;
  logic [PW-1:0]    arb_idx;
  logic [PW-1:0]    ptr_nxt;
  logic             nibble_hit;
  logic             last_nib;

  rr_arbiter_n #(.N(N_REQ), .PW(PW)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_gnt),
    .valid (arb_vld)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) arb_idx = PW'(i);
    end
  end

  assign ptr_nxt = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);

  // Rising edge of done only: a level held across a pause must not count twice.
  assign nibble_hit = prng_done && !done_q && (state == COLLECT);
  assign last_nib   = (nib_cnt == CW'(WORD_NIBBLES - 1));
  assign busy       = (state != IDLE);

  always_comb begin
    word_nxt = word;
    word_nxt[PRNG_NIBBLE_W*int'(nib_cnt) +: PRNG_NIBBLE_W] = prng_dout;
  end

`ifdef PRNG_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (res) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      gnt_oh   <= '0;
      word     <= '0;
      nib_cnt  <= '0;
      done_q   <= 1'b0;
      res_q    <= 1'b1;
      ack      <= '0;
      rsp_data <= '0;
      prng_ena <= 1'b0;
      prng_res <= 1'b1;
`ifdef PRNG_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      done_q   <= prng_done;
      res_q    <= 1'b0;
      ack      <= '0;
      prng_res <= res_q;
`ifdef PRNG_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          // Hold off while the generator is still being reset.
          if (arb_vld && !prng_res) begin
            gnt_oh   <= arb_gnt;
            gnt_idx  <= arb_idx;
            word     <= '0;
            nib_cnt  <= '0;
            prng_ena <= 1'b1;
            state    <= COLLECT;
`ifdef PRNG_ARB_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end
        end
        COLLECT: begin
          if (nibble_hit) begin
            word <= word_nxt;
`ifdef PRNG_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            if (last_nib) begin
              // ack and data land together in the DELIVER cycle.
              rsp_data <= word_nxt;
              ack      <= gnt_oh & req;
              prng_ena <= 1'b0;
              state    <= DELIVER;
            end else begin
              nib_cnt <= nib_cnt + CW'(1);
            end
          end
`ifdef PRNG_ARB_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            prng_ena    <= 1'b0;
            prng_res    <= 1'b1;
            ptr         <= ptr_nxt;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end
        DELIVER: begin
          ptr   <= ptr_nxt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prng_arbiter.sv
module tb_prng_arbiter;
  import prng_pkg::*;

  localparam int N   = 4;
  localparam int WN  = 2;
  localparam int W   = 4 * WN;
  localparam int TMO = 10;

  logic         clk = 1'b0;
  logic         res = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] ack;
  logic [W-1:0] rsp_data;
  logic         busy, timeout_err, prng_ena, prng_res;
  logic [3:0]   prng_dout;
  logic         prng_done;

  // PRNG behavioural model outputs and manual override
  logic       manual  = 1'b0;
  logic       man_done = 1'b0;
  logic [3:0] man_dout = '0;
  logic       mdl_done = 1'b0;
  logic [3:0] mdl_dout = '0;

  assign prng_done = manual ? man_done : mdl_done;
  assign prng_dout = manual ? man_dout : mdl_dout;

  int checks = 0;
  int failures = 0;

  // Scoreboard: nibbles emitted by the model, grouped into words LSB-first.
  int         en_cnt = 0;
  int         nacc = 0;
  logic [W-1:0] acc = '0;
  logic [W-1:0] last_word = '0;

  always #5 clk = ~clk;

  prng_arbiter #(.N_REQ(N), .WORD_NIBBLES(WN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .res(res), .req(req), .ack(ack), .rsp_data(rsp_data),
    .busy(busy), .timeout_err(timeout_err), .prng_ena(prng_ena),
    .prng_res(prng_res), .prng_dout(prng_dout), .prng_done(prng_done)
  );

  // Generator model: warm-up, then one nibble every PRNG_NIBBLE_CYCLES enabled cycles.
  always @(posedge clk) begin
    logic [3:0] nib;
    if (res) begin
      acc  = '0;
      nacc = 0;
    end
    if (prng_res === 1'b1) begin
      en_cnt = 0;
      mdl_done <= 1'b0;
    end else if (prng_ena === 1'b1) begin
      en_cnt = en_cnt + 1;
      if (en_cnt >= PRNG_WARMUP_CYCLES + PRNG_NIBBLE_CYCLES &&
          ((en_cnt - PRNG_WARMUP_CYCLES) % PRNG_NIBBLE_CYCLES) == 0) begin
        nib = 4'($urandom_range(0, 15));
        mdl_dout <= nib;
        mdl_done <= 1'b1;
        if (!manual && !res) begin
          acc[4*nacc +: 4] = nib;
          nacc = nacc + 1;
          if (nacc == WN) begin
            last_word = acc;
            acc  = '0;
            nacc = 0;
          end
        end
      end else begin
        mdl_done <= 1'b0;
      end
    end else begin
      mdl_done <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int idx, output int en_cyc);
    idx = -1;
    en_cyc = 0;
    for (int c = 0; c < 3000 && idx < 0; c++) begin
      @(negedge clk);
      if (prng_ena === 1'b1) en_cyc++;
      if (|ack) begin
        for (int i = 0; i < N; i++) if (ack[i]) idx = i;
      end
    end
    if (idx < 0) begin
      checks++;
      failures++;
      $error("FAIL ack_timeout observed=none expected=ack");
    end else begin
      chk("ack_onehot", 32'($onehot(ack)), 32'd1);
    end
  endtask

  task automatic wait_ena(input logic v);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (prng_ena !== v && c < 3000);
    if (prng_ena !== v) begin
      checks++;
      failures++;
      $error("FAIL ena_timeout observed=%0b expected=%0b", prng_ena, v);
    end
  endtask

  task automatic do_reset();
    res = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ena", 32'(prng_ena), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    chk("rst_prng_res", 32'(prng_res), 32'd1);
    res = 1'b0;
    @(negedge clk);
    chk("prng_res_post", 32'(prng_res), 32'd1);
    @(negedge clk);
    chk("prng_res_drop", 32'(prng_res), 32'd0);
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++) if (m[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  initial begin
    int idx, en_cyc, ptr_m, cnt;
    logic [3:0] na, nb, nc, nd;
    logic [N-1:0] mask;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    // 1: single requester, warm-up latency and nibble packing
    do_reset();
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    req = 4'b0001;
    wait_ack(idx, en_cyc);
    chk("t1_ack_idx", 32'(idx), 32'd0);
    chk("t1_latency_ok", 32'(en_cyc >= PRNG_WARMUP_CYCLES + WN * PRNG_NIBBLE_CYCLES), 32'd1);
    chk("t1_data", 32'(rsp_data), 32'(last_word));
    req = '0;
    @(negedge clk);
    chk("t1_ack_pulse", 32'(ack), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_data_hold", 32'(rsp_data), 32'(last_word));

    // 2: all requesting, strict rotation
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(idx, en_cyc);
      chk("t2_order", 32'(idx), 32'(exp_order[k]));
      chk("t2_data", 32'(rsp_data), 32'(last_word));
    end
    req = '0;

    // 3: grantee drops req mid-collection, word discarded
    do_reset();
    req = 4'b1100;
    wait_ena(1'b1);
    repeat (10) @(negedge clk);
    req[2] = 1'b0;
    wait_ena(1'b0);
    chk("t3_deliver_busy", 32'(busy), 32'd1);
    chk("t3_no_ack2", 32'(ack), 32'd0);
    wait_ack(idx, en_cyc);
    chk("t3_next_grant", 32'(idx), 32'd3);
    chk("t3_data", 32'(rsp_data), 32'(last_word));
    req = '0;

    // 4: done held high across an IDLE pause
    manual = 1'b1;
    man_done = 1'b0;
    do_reset();
    req = 4'b0001;
    wait_ena(1'b1);
    repeat (2) @(negedge clk);
    na = 4'($urandom_range(0, 15));
    nb = 4'($urandom_range(0, 15));
    man_dout = na; man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    man_dout = nb; man_done = 1'b1;
    wait_ack(idx, en_cyc);
    chk("t4_ack0", 32'(idx), 32'd0);
    chk("t4_word0", 32'(rsp_data), 32'({nb, na}));
    nc = 4'($urandom_range(0, 15));
    nd = 4'($urandom_range(0, 15));
    man_dout = nc ^ 4'hF;  // stale value visible while done stays high
    wait_ena(1'b1);
    repeat (3) @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    man_dout = nc; man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    man_dout = nd; man_done = 1'b1;
    wait_ack(idx, en_cyc);
    chk("t4_ack1", 32'(idx), 32'd0);
    chk("t4_word1", 32'(rsp_data), 32'({nd, nc}));
    man_done = 1'b0;
    req = '0;
    manual = 1'b0;

    // 5: reset during collection restarts pointer at 0
    do_reset();
    req = 4'b0001;
    wait_ack(idx, en_cyc);
    chk("t5_first", 32'(idx), 32'd0);
    req = 4'b0011;
    wait_ena(1'b1);
    repeat (5) @(negedge clk);
    do_reset();
    wait_ack(idx, en_cyc);
    chk("t5_ptr_reset", 32'(idx), 32'd0);
    chk("t5_data", 32'(rsp_data), 32'(last_word));
    req = '0;

`ifdef PRNG_ARB_TIMEOUT_EN
    // 6: watchdog with done stuck low
    manual = 1'b1;
    man_done = 1'b0;
    do_reset();
    req = 4'b0011;
    wait_ena(1'b1);
    cnt = 1;
    while (timeout_err !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      if (prng_ena === 1'b1) cnt++;
    end
    chk("t6_tmo_cycles", 32'(cnt), 32'(TMO));
    chk("t6_tmo_ena", 32'(prng_ena), 32'd0);
    chk("t6_tmo_prng_res", 32'(prng_res), 32'd1);
    chk("t6_tmo_ack", 32'(ack), 32'd0);
    manual = 1'b0;
    @(negedge clk);
    chk("t6_tmo_pulse", 32'(timeout_err), 32'd0);
    wait_ack(idx, en_cyc);
    chk("t6_next_grant", 32'(idx), 32'd1);
    req = '0;
`endif

    // 7: random request sets against a round-robin reference
    do_reset();
    ptr_m = 0;
    mask = N'($urandom_range(1, 15));
    req = mask;
    for (int k = 0; k < 12; k++) begin
      int exp_idx;
      exp_idx = rr_pick(mask, ptr_m);
      wait_ack(idx, en_cyc);
      chk("t7_grant", 32'(idx), 32'(exp_idx));
      chk("t7_data", 32'(rsp_data), 32'(last_word));
      if (idx >= 0) begin
        mask[idx] = 1'b0;
        ptr_m = (idx + 1) % N;
      end
      mask = mask | N'($urandom_range(0, 15));
      if (mask == '0) mask[$urandom_range(0, N - 1)] = 1'b1;
      req = mask;
    end
    req = '0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
